// File: rtl/conv_output_collector.sv
//==============================================================================
//  Module      : conv_output_collector
//  Description : Output sink for the convolution engine. Requantizes each
//                incoming accumulator (arithmetic shift, optional ReLU,
//                saturation), stores results row-major into an OUT_H x OUT_W
//                buffer, flags frame completion and exposes the buffer through
//                a registered random-access read port.
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module conv_output_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_H      = 3,
    parameter int OUT_W      = 3,
    parameter int SHIFT      = 0,
    parameter int RELU       = 1,
    // Derived widths; not intended to be overridden.
    parameter int DEPTH      = OUT_H * OUT_W,
    parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic signed [ACC_WIDTH-1:0]  in_pixel,
    input  logic                         in_valid,
    input  logic        [ADDR_W-1:0]     rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data,
    output logic        [CNT_W-1:0]      pixel_count,
    output logic                         frame_done,
    output logic                         overflow,
    output logic                         saturated
);

    // Collector state encoding
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_collect = 2'd1;
    localparam logic [1:0] c_st_full    = 2'd2;

    // Clip limits expressed at accumulator width so the compare is exact
    localparam logic signed [ACC_WIDTH-1:0] c_qmax =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_qmin =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DEPTH - 1);

    logic [1:0]                   r_state;
    logic [ADDR_W-1:0]            r_wr_ptr;
    logic [CNT_W-1:0]             r_count;
    logic                         r_done;
    logic                         r_ovf;
    logic                         r_sat;
    logic signed [DATA_WIDTH-1:0] r_rd_data;
    logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic signed [ACC_WIDTH-1:0]  w_shifted;
    logic signed [DATA_WIDTH-1:0] w_q;
    logic                         w_clip;
    logic                         w_wr_en;
    logic                         w_not_collecting;
    logic                         w_rd_in_range;

    assign w_shifted        = in_pixel >>> SHIFT;
    assign w_not_collecting = (r_state == c_st_idle) || (r_state == c_st_full);
    // arm wins over a coincident pixel, so that pixel is never written
    assign w_wr_en          = in_valid && !arm && (r_state == c_st_collect);
    assign w_rd_in_range    = (32'(rd_addr) < 32'(DEPTH));

    // Requantize: ReLU clamp first (not counted as saturation), then clip
    always_comb begin
        w_q    = w_shifted[DATA_WIDTH-1:0];
        w_clip = 1'b0;
        if ((RELU != 0) && (w_shifted < 0)) begin
            w_q = '0;
        end else if (w_shifted > c_qmax) begin
            w_q    = c_qmax[DATA_WIDTH-1:0];
            w_clip = 1'b1;
        end else if (w_shifted < c_qmin) begin
            w_q    = c_qmin[DATA_WIDTH-1:0];
            w_clip = 1'b1;
        end
    end

    // Control FSM, counters and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_sat    <= 1'b0;
        end else if (arm) begin
            r_state  <= c_st_collect;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_sat    <= 1'b0;
        end else if (in_valid) begin
            if (w_not_collecting) begin
                r_ovf <= 1'b1;
            end else begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                r_count  <= r_count + CNT_W'(1);
                if (w_clip) begin
                    r_sat <= 1'b1;
                end
                if (r_count == c_last_cnt) begin
                    r_state <= c_st_full;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    // Frame buffer write; contents intentionally survive reset and arm
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_q;
        end
    end

    // Registered read port; non-blocking update gives read-before-write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (w_rd_in_range) begin
            r_rd_data <= r_mem[rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign rd_data     = r_rd_data;
    assign pixel_count = r_count;
    assign frame_done  = r_done;
    assign overflow    = r_ovf;
    assign saturated   = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_conv_output_collector.sv
//==============================================================================
//  Module      : tb_conv_output_collector
//  Description : Scoreboard bench for conv_output_collector. Three instances
//                share stimulus: (SHIFT=0,RELU=1), (SHIFT=0,RELU=0) and
//                (SHIFT=2,RELU=1).
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_conv_output_collector;

    localparam int c_f_rd   = 0;
    localparam int c_f_cnt  = 1;
    localparam int c_f_done = 2;
    localparam int c_f_ovf  = 3;
    localparam int c_f_sat  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               arm = 1'b0;
    logic signed [31:0] in_pixel = '0;
    logic               in_valid = 1'b0;
    logic        [3:0]  rd_addr = '0;

    logic signed [7:0]  rd_data_a [3];
    logic        [3:0]  cnt_a     [3];
    logic               done_a    [3];
    logic               ovf_a     [3];
    logic               sat_a     [3];

    typedef struct {
        int    sel;
        int    ev;
        string name;
    } item_t;

    item_t sbq[$];
    logic  chk_en = 1'b0;
    int    total  = 0;
    int    bad    = 0;

    always #5 clk = ~clk;

    conv_output_collector #(.DATA_WIDTH(8), .ACC_WIDTH(32), .OUT_H(3), .OUT_W(3),
                            .SHIFT(0), .RELU(1)) u0 (
        .clk(clk), .rst(rst), .arm(arm), .in_pixel(in_pixel), .in_valid(in_valid),
        .rd_addr(rd_addr), .rd_data(rd_data_a[0]), .pixel_count(cnt_a[0]),
        .frame_done(done_a[0]), .overflow(ovf_a[0]), .saturated(sat_a[0]));

    conv_output_collector #(.DATA_WIDTH(8), .ACC_WIDTH(32), .OUT_H(3), .OUT_W(3),
                            .SHIFT(0), .RELU(0)) u1 (
        .clk(clk), .rst(rst), .arm(arm), .in_pixel(in_pixel), .in_valid(in_valid),
        .rd_addr(rd_addr), .rd_data(rd_data_a[1]), .pixel_count(cnt_a[1]),
        .frame_done(done_a[1]), .overflow(ovf_a[1]), .saturated(sat_a[1]));

    conv_output_collector #(.DATA_WIDTH(8), .ACC_WIDTH(32), .OUT_H(3), .OUT_W(3),
                            .SHIFT(2), .RELU(1)) u2 (
        .clk(clk), .rst(rst), .arm(arm), .in_pixel(in_pixel), .in_valid(in_valid),
        .rd_addr(rd_addr), .rd_data(rd_data_a[2]), .pixel_count(cnt_a[2]),
        .frame_done(done_a[2]), .overflow(ovf_a[2]), .saturated(sat_a[2]));

    function automatic int get(int sel);
        int inst = sel / 8;
        case (sel % 8)
            c_f_rd:   return int'(rd_data_a[inst]);
            c_f_cnt:  return int'(cnt_a[inst]);
            c_f_done: return int'(done_a[inst]);
            c_f_ovf:  return int'(ovf_a[inst]);
            default:  return int'(sat_a[inst]);
        endcase
    endfunction

    task automatic check(string name, int inst, int act, int ev);
        total++;
        if (act !== ev) begin
            bad++;
            $display("FAIL %s (u%0d): got %0d expected %0d", name, inst, act, ev);
        end
    endtask

    // Drive one cycle of inputs on the falling edge
    task automatic drive(logic a, logic v, int p, int ra);
        @(negedge clk);
        arm      = a;
        in_valid = v;
        in_pixel = p;
        rd_addr  = 4'(ra);
        chk_en   = 1'b0;
    endtask

    // Queue expected values (one per instance) for the upcoming edge
    task automatic exp3(int field, int e0, int e1, int e2, string name);
        item_t it;
        int    ev[3];
        ev = '{e0, e1, e2};
        for (int i = 0; i < 3; i++) begin
            it.sel  = i * 8 + field;
            it.ev   = ev[i];
            it.name = name;
            sbq.push_back(it);
        end
        chk_en = 1'b1;
    endtask

    task automatic check_all_zero(string name);
        for (int i = 0; i < 3; i++) begin
            check({name, "_rd"},   i, get(i * 8 + c_f_rd),   0);
            check({name, "_cnt"},  i, get(i * 8 + c_f_cnt),  0);
            check({name, "_done"}, i, get(i * 8 + c_f_done), 0);
            check({name, "_ovf"},  i, get(i * 8 + c_f_ovf),  0);
            check({name, "_sat"},  i, get(i * 8 + c_f_sat),  0);
        end
    endtask

    // Monitor: after each edge that has queued expectations, drain and compare
    initial begin
        item_t it;
        logic  en;
        forever begin
            @(posedge clk);
            en = chk_en;
            #1;
            if (en) begin
                while (sbq.size() > 0) begin
                    it = sbq.pop_front();
                    check(it.name, it.sel / 8, get(it.sel), it.ev);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_u0[5] = '{127, 0, 127, 127, 0};
        int a_u1[5] = '{127, -5, 127, 127, -128};
        int a_u2[5] = '{75, 0, 31, 32, 0};
        int pix_a[5] = '{300, -5, 127, 128, -200};

        // Reset state while rst is held
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Pixel while idle: overflow, nothing counted
        drive(1'b0, 1'b1, 5, 0);
        exp3(c_f_ovf, 1, 1, 1, "idle_ovf");
        exp3(c_f_cnt, 0, 0, 0, "idle_cnt");

        // Arm clears overflow
        drive(1'b1, 1'b0, 0, 0);
        exp3(c_f_ovf, 0, 0, 0, "arm_ovf");
        exp3(c_f_cnt, 0, 0, 0, "arm_cnt");

        // Frame A: saturation / ReLU patterns
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, pix_a[i], 0);
            exp3(c_f_cnt, i + 1, i + 1, i + 1, "satfrm_cnt");
        end
        exp3(c_f_sat, 1, 1, 0, "satfrm_sat");
        exp3(c_f_done, 0, 0, 0, "satfrm_done");
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 0, i);
            exp3(c_f_rd, a_u0[i], a_u1[i], a_u2[i], "satfrm_rd");
        end

        // Re-arm mid-frame with a coincident pixel: pixel dropped, all cleared
        drive(1'b1, 1'b1, 77, 0);
        exp3(c_f_cnt, 0, 0, 0, "rearm_cnt");
        exp3(c_f_sat, 0, 0, 0, "rearm_sat");
        exp3(c_f_ovf, 0, 0, 0, "rearm_ovf");
        exp3(c_f_done, 0, 0, 0, "rearm_done");
        drive(1'b0, 1'b1, 42, 0);
        exp3(c_f_cnt, 1, 1, 1, "rearm_first_cnt");

        // Collision: write addr 1 while reading addr 1 -> old, then new
        drive(1'b0, 1'b1, 2, 1);
        exp3(c_f_rd, 0, -5, 0, "collide_old");
        drive(1'b0, 1'b0, 0, 1);
        exp3(c_f_rd, 2, 2, 0, "collide_new");
        drive(1'b0, 1'b0, 0, 0);
        exp3(c_f_rd, 42, 42, 10, "rearm_addr0");

        // Frame B: 1..9 with random gaps
        drive(1'b1, 1'b0, 0, 0);
        exp3(c_f_cnt, 0, 0, 0, "frmB_arm_cnt");
        for (int i = 1; i <= 9; i++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'b0, 0, 0);
            end
            drive(1'b0, 1'b1, i, 0);
            exp3(c_f_cnt, i, i, i, "frmB_cnt");
            exp3(c_f_done, (i == 9) ? 1 : 0, (i == 9) ? 1 : 0, (i == 9) ? 1 : 0,
                 "frmB_done");
        end
        exp3(c_f_sat, 0, 0, 0, "frmB_sat");
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, 0, i);
            exp3(c_f_rd, i + 1, i + 1, (i + 1) / 4, "frmB_rd");
        end
        drive(1'b0, 1'b0, 0, 12);
        exp3(c_f_rd, 0, 0, 0, "rd_out_of_range");

        // Overflow after full frame
        drive(1'b0, 1'b1, 99, 0);
        exp3(c_f_ovf, 1, 1, 1, "full_ovf");
        exp3(c_f_cnt, 9, 9, 9, "full_cnt");
        exp3(c_f_done, 1, 1, 1, "full_done");
        exp3(c_f_rd, 1, 1, 0, "full_addr0");
        drive(1'b0, 1'b0, 0, 0);
        exp3(c_f_rd, 1, 1, 0, "full_addr0_again");

        // Asynchronous reset mid-cycle: outputs clear before the next edge
        drive(1'b0, 1'b0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;

        drive(1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 0, 0);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
